alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, fully pipelined signed ALU with valid/ready handshakes on both sides.
//  - Successor to the single-stage registered ALU.
//  - Adds: 8 ops, a multi-stage multiplier, backpressure with bubble collapse,
//    overflow/illegal flags, optional saturation.
//  - Sits between an operand-issue front end and a result sink; one op accepted per cycle.
// PARAMETERS
//  DATAW        16  operand/result width, signed two's complement, >=4
//  OPCODEW      3   opcode width, >=3; codes 8..2**OPCODEW-1 are illegal
//  MULT_STAGES  2   multiplier pipeline depth, >=1; LAT = MULT_STAGES+2
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        block can accept a beat this cycle
//  opcode     in   OPCODEW  unsigned opcode (see BEHAVIOUR)
//  dataa      in   DATAW    signed operand A
//  datab      in   DATAW    signed operand B
//  out_valid  out  1        result beat valid
//  out_ready  in   1        sink accepts result
//  result     out  DATAW    signed result
//  ovf        out  1        signed overflow of this result (0 for logic ops / mulh)
//  illegal    out  1        opcode was illegal; result forced to 0
// BEHAVIOUR
//  - Opcodes: 0 a+b | 1 a-b | 2 b-a | 3 mull = prod[DATAW-1:0]
//    | 4 mulh = prod[2*DATAW-1:DATAW] | 5 a&b | 6 a|b | 7 a^b.
//  - prod is the full 2*DATAW signed product.
//  - Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready.
//  - Pipeline: LAT stages.
//    - S0: input register.
//    - S1..S(LAT-2): execute. Non-mult ops are computed in S1 and carried alongside the multiplier.
//    - S(LAT-1): output register, which drives result/ovf/illegal.
//  - Latency: accepted beat appears at out_valid exactly LAT cycles later when out_ready is held 1.
//  - Throughput: 1 beat/cycle. Ordering strictly in-order.
//  - Stall: each stage has a valid bit.
//    - A stage loads when it is empty or its successor loads.
//    - Bubbles collapse under stall.
//    - in_ready = !v[S0] || S0 advancing.
//    - With out_ready=0, at most LAT beats are held.
//  - Held output: result/ovf/illegal are stable while out_valid && !out_ready.
//  - ovf:
//    - add: sign(a)==sign(b) && sign(sum)!=sign(a).
//    - sub: same rule on the effective operands.
//    - mull: prod does not fit in DATAW signed.
//  - Wrap: default results wrap modulo 2**DATAW.
//  - Reset, asserted at any time, including mid-stream:
//    - All valid bits clear and all data registers go to 0.
//    - Outputs: out_valid=0, result=0, ovf=0, illegal=0, in_ready=0 while rst_n=0.
//    - in_ready=1 from the first cycle after deassertion.
//    - In-flight beats are dropped, not replayed.
// CONFIGURATION
//  ALU_PIPE_SAT_EN
//  - Defined: ops 0/1/2/3 saturate on ovf to 2**(DATAW-1)-1 (positive overflow)
//    or -2**(DATAW-1) (negative overflow). ovf still reports the overflow.
//  - Undefined: wrap-around results. ovf is a flag only.
// STRUCTURE
//  Package alu_pipe_pkg:
//  - opcode_e enum: OP_ADD..OP_XOR.
//  - OP_NUM=8.
//  - Function alu_lat(MULT_STAGES).
//  - Function sat_val(DATAW, sign).
//  Sub-module alu_pipe_mult:
//  - DATAW-by-DATAW signed multiplier, MULT_STAGES register stages.
//  - Per-stage enable is driven by the parent's stall logic.
//  - Same rst_n.
// TESTING
//  1. Reset, then back-to-back adds 3+4, 100+(-1), -5-7 (op1), out_ready=1
//     -> 7, 99, -12 on consecutive cycles, each LAT cycles after input. ovf=0.
//  2. DATAW=16, op3 with 300*300 -> result 0x5F90, ovf=1.
//     - ALU_PIPE_SAT_EN: result 32767.
//     - Same operands, op4 -> 0x0001, ovf=0.
//  3. Op0 32767+1 -> -32768, ovf=1; -32768-1 (op1) -> 32767, ovf=1.
//     - ALU_PIPE_SAT_EN: results 32767 and -32768.
//  4. out_ready=0 while issuing 6 beats with LAT=4 -> in_ready falls after 4 accepted.
//     - Beat 1 result held stable.
//     - Releasing out_ready drains all 4 in order, then beats 5-6 follow; no loss, no duplication.
//  5. OPCODEW=4, opcode 9 with a=5, b=5 -> result 0, illegal=1, ovf=0.
//  6. Assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately (async).
//     - After release, no stale beat emerges; a new op 5 (0xF0F0&0x0FF0) -> 0x00F0.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared opcode type and helpers for the pipelined signed ALU.
// Used by alu_pipe and alu_pipe_mult.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_RSUB = 3'd2,
        OP_MULL = 3'd3,
        OP_MULH = 3'd4,
        OP_AND  = 3'd5,
        OP_OR   = 3'd6,
        OP_XOR  = 3'd7
    } opcode_e;

    localparam int OP_NUM = 8;

    function automatic int alu_lat(input int mult_stages);
        return mult_stages + 2;
    endfunction

    // Saturation bound for a dataw-bit signed value; caller keeps the low dataw bits.
    function automatic logic [63:0] sat_val(input int dataw, input logic neg);
        logic [63:0] v;
        if (neg) v = {64{1'b1}} << (dataw - 1);
        else     v = (64'd1 << (dataw - 1)) - 64'd1;
        return v;
    endfunction

endpackage

// File: rtl/alu_pipe_mult.sv
// DATAW x DATAW signed multiplier with MULT_STAGES register stages.
// Each stage advances only when the parent pipeline enables it.
module alu_pipe_mult
    import alu_pipe_pkg::*;
#(
    parameter int DATAW       = 16,
    parameter int MULT_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [MULT_STAGES-1:0]    en,
    input  logic signed [DATAW-1:0]   a,
    input  logic signed [DATAW-1:0]   b,
    output logic signed [2*DATAW-1:0] prod
);

    localparam int PW = 2 * DATAW;

    logic signed [PW-1:0] prod_q [MULT_STAGES];
    logic signed [PW-1:0] prod_d [MULT_STAGES];

    always_comb begin
        for (int k = 0; k < MULT_STAGES; k++) prod_d[k] = prod_q[k];
        if (en[0]) prod_d[0] = PW'(a) * PW'(b);
        for (int k = 1; k < MULT_STAGES; k++) begin
            if (en[k]) prod_d[k] = prod_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MULT_STAGES; k++) prod_q[k] <= '0;
        end else begin
            for (int k = 0; k < MULT_STAGES; k++) prod_q[k] <= prod_d[k];
        end
    end

    assign prod = prod_q[MULT_STAGES-1];

endmodule

// File: rtl/alu_pipe.sv
// Fully pipelined signed ALU with valid/ready on both sides and bubble-collapsing stalls.
// Optional saturation of add/sub/mull results when ALU_PIPE_SAT_EN is defined.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int DATAW       = 16,
    parameter int OPCODEW     = 3,
    parameter int MULT_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPCODEW-1:0] opcode,
    input  logic [DATAW-1:0]   dataa,
    input  logic [DATAW-1:0]   datab,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATAW-1:0]   result,
    output logic               ovf,
    output logic               illegal
);

    localparam int LAT = alu_lat(MULT_STAGES);
    localparam int M   = MULT_STAGES;
`ifdef ALU_PIPE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam logic signed [DATAW-1:0] SAT_POS = DATAW'(sat_val(DATAW, 1'b0));
    localparam logic signed [DATAW-1:0] SAT_NEG = DATAW'(sat_val(DATAW, 1'b1));

    logic                      s0_v_q, s0_v_d;
    logic [OPCODEW-1:0]        s0_opc_q, s0_opc_d;
    logic signed [DATAW-1:0]   s0_a_q, s0_a_d, s0_b_q, s0_b_d;

    logic                      ex_v_q   [M];
    logic                      ex_v_d   [M];
    opcode_e                   ex_op_q  [M];
    opcode_e                   ex_op_d  [M];
    logic                      ex_ill_q [M];
    logic                      ex_ill_d [M];
    logic                      ex_ovf_q [M];
    logic                      ex_ovf_d [M];
    logic signed [DATAW-1:0]   ex_res_q [M];
    logic signed [DATAW-1:0]   ex_res_d [M];

    logic                      out_v_q, out_v_d;
    logic signed [DATAW-1:0]   out_res_q, out_res_d;
    logic                      out_ovf_q, out_ovf_d;
    logic                      out_ill_q, out_ill_d;

    logic [LAT-1:0]            v_all, en_all;
    logic signed [2*DATAW-1:0] prod;

    opcode_e                   s1_op;
    logic                      s1_ill, s1_ovf;
    logic signed [DATAW-1:0]   s1_res;

    logic signed [DATAW-1:0]   fin_res;
    logic                      fin_ovf, mull_ovf;

    // A stage stalls only if it and every stage downstream of it is full while the sink refuses.
    always_comb begin
        logic stall;
        v_all[0] = s0_v_q;
        for (int k = 0; k < M; k++) v_all[k+1] = ex_v_q[k];
        v_all[LAT-1] = out_v_q;
        stall  = !out_ready;
        en_all = '0;
        for (int k = LAT - 1; k >= 0; k--) begin
            stall     = stall && v_all[k];
            en_all[k] = !stall;
        end
    end

    always_comb begin
        logic first_neg;
        s1_op     = opcode_e'(s0_opc_q[2:0]);
        s1_ill    = (32'(s0_opc_q) >= 32'(OP_NUM));
        s1_res    = '0;
        s1_ovf    = 1'b0;
        first_neg = s0_a_q[DATAW-1];
        case (s1_op)
            OP_ADD: begin
                s1_res = s0_a_q + s0_b_q;
                s1_ovf = (s0_a_q[DATAW-1] == s0_b_q[DATAW-1]) && (s1_res[DATAW-1] != s0_a_q[DATAW-1]);
            end
            OP_SUB: begin
                s1_res = s0_a_q - s0_b_q;
                s1_ovf = (s0_a_q[DATAW-1] != s0_b_q[DATAW-1]) && (s1_res[DATAW-1] != s0_a_q[DATAW-1]);
            end
            OP_RSUB: begin
                s1_res    = s0_b_q - s0_a_q;
                s1_ovf    = (s0_a_q[DATAW-1] != s0_b_q[DATAW-1]) && (s1_res[DATAW-1] != s0_b_q[DATAW-1]);
                first_neg = s0_b_q[DATAW-1];
            end
            OP_AND:  s1_res = s0_a_q & s0_b_q;
            OP_OR:   s1_res = s0_a_q | s0_b_q;
            OP_XOR:  s1_res = s0_a_q ^ s0_b_q;
            default: s1_res = '0;
        endcase
        if (SAT_EN && s1_ovf) s1_res = first_neg ? SAT_NEG : SAT_POS;
        if (s1_ill) begin
            s1_res = '0;
            s1_ovf = 1'b0;
        end
    end

    // Multiplier results join the carried non-mult results at the output register.
    always_comb begin
        mull_ovf = (prod[2*DATAW-1:DATAW-1] != '0) && (prod[2*DATAW-1:DATAW-1] != '1);
        fin_res  = ex_res_q[M-1];
        fin_ovf  = ex_ovf_q[M-1];
        case (ex_op_q[M-1])
            OP_MULL: begin
                fin_res = prod[DATAW-1:0];
                fin_ovf = mull_ovf;
                if (SAT_EN && mull_ovf) fin_res = prod[2*DATAW-1] ? SAT_NEG : SAT_POS;
            end
            OP_MULH: begin
                fin_res = prod[2*DATAW-1:DATAW];
                fin_ovf = 1'b0;
            end
            default: ;
        endcase
        if (ex_ill_q[M-1]) begin
            fin_res = '0;
            fin_ovf = 1'b0;
        end
    end

    always_comb begin
        s0_v_d   = s0_v_q;
        s0_opc_d = s0_opc_q;
        s0_a_d   = s0_a_q;
        s0_b_d   = s0_b_q;
        if (en_all[0]) begin
            s0_v_d   = in_valid;
            s0_opc_d = opcode;
            s0_a_d   = dataa;
            s0_b_d   = datab;
        end

        for (int k = 0; k < M; k++) begin
            ex_v_d[k]   = ex_v_q[k];
            ex_op_d[k]  = ex_op_q[k];
            ex_ill_d[k] = ex_ill_q[k];
            ex_ovf_d[k] = ex_ovf_q[k];
            ex_res_d[k] = ex_res_q[k];
        end
        if (en_all[1]) begin
            ex_v_d[0]   = s0_v_q;
            ex_op_d[0]  = s1_op;
            ex_ill_d[0] = s1_ill;
            ex_ovf_d[0] = s1_ovf;
            ex_res_d[0] = s1_res;
        end
        for (int k = 1; k < M; k++) begin
            if (en_all[k+1]) begin
                ex_v_d[k]   = ex_v_q[k-1];
                ex_op_d[k]  = ex_op_q[k-1];
                ex_ill_d[k] = ex_ill_q[k-1];
                ex_ovf_d[k] = ex_ovf_q[k-1];
                ex_res_d[k] = ex_res_q[k-1];
            end
        end

        out_v_d   = out_v_q;
        out_res_d = out_res_q;
        out_ovf_d = out_ovf_q;
        out_ill_d = out_ill_q;
        if (en_all[LAT-1]) begin
            out_v_d   = ex_v_q[M-1];
            out_res_d = fin_res;
            out_ovf_d = fin_ovf;
            out_ill_d = ex_ill_q[M-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_v_q   <= 1'b0;
            s0_opc_q <= '0;
            s0_a_q   <= '0;
            s0_b_q   <= '0;
            for (int k = 0; k < M; k++) begin
                ex_v_q[k]   <= 1'b0;
                ex_op_q[k]  <= OP_ADD;
                ex_ill_q[k] <= 1'b0;
                ex_ovf_q[k] <= 1'b0;
                ex_res_q[k] <= '0;
            end
            out_v_q   <= 1'b0;
            out_res_q <= '0;
            out_ovf_q <= 1'b0;
            out_ill_q <= 1'b0;
        end else begin
            s0_v_q   <= s0_v_d;
            s0_opc_q <= s0_opc_d;
            s0_a_q   <= s0_a_d;
            s0_b_q   <= s0_b_d;
            for (int k = 0; k < M; k++) begin
                ex_v_q[k]   <= ex_v_d[k];
                ex_op_q[k]  <= ex_op_d[k];
                ex_ill_q[k] <= ex_ill_d[k];
                ex_ovf_q[k] <= ex_ovf_d[k];
                ex_res_q[k] <= ex_res_d[k];
            end
            out_v_q   <= out_v_d;
            out_res_q <= out_res_d;
            out_ovf_q <= out_ovf_d;
            out_ill_q <= out_ill_d;
        end
    end

    alu_pipe_mult #(
        .DATAW       (DATAW),
        .MULT_STAGES (MULT_STAGES)
    ) u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_all[M:1]),
        .a     (s0_a_q),
        .b     (s0_b_q),
        .prod  (prod)
    );

    assign in_ready  = rst_n && en_all[0];
    assign out_valid = out_v_q;
    assign result    = out_res_q;
    assign ovf       = out_ovf_q;
    assign illegal   = out_ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, stall/reset sequences,
// and randomized traffic against an arithmetic reference model.
module tb_alu_pipe;

    localparam int DATAW       = 16;
    localparam int OPCODEW     = 4;
    localparam int MULT_STAGES = 2;
    localparam int LAT         = MULT_STAGES + 2;
`ifdef ALU_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [OPCODEW-1:0] opcode = '0;
    logic [DATAW-1:0]   dataa = '0;
    logic [DATAW-1:0]   datab = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [DATAW-1:0]   result;
    logic               ovf;
    logic               illegal;

    alu_pipe #(.DATAW(DATAW), .OPCODEW(OPCODEW), .MULT_STAGES(MULT_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .dataa(dataa), .datab(datab), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .ovf(ovf), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        ill;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        ovf;
        logic        ill;
    } vec_t;

    exp_t sb_q[$];
    exp_t pend;
    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   fired_in;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then range check / wrap / clamp.
    function automatic exp_t model(input int op, input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint sa, sb, full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.res = '0; e.ovf = 1'b0; e.ill = 1'b0; e.cyc = 0; e.chk_lat = 1'b0;
        full = 0;
        if (op <= 3) begin
            case (op)
                0: full = sa + sb;
                1: full = sa - sb;
                2: full = sb - sa;
                default: full = sa * sb;
            endcase
            e.ovf = (full > 32767) || (full < -32768);
            e.res = full[15:0];
            if (SAT && full > 32767)  e.res = 16'h7fff;
            if (SAT && full < -32768) e.res = 16'h8000;
        end else if (op == 4) begin
            full  = sa * sb;
            e.res = full[31:16];
        end else if (op == 5) e.res = a & b;
        else if (op == 6)     e.res = a | b;
        else if (op == 7)     e.res = a ^ b;
        else                  e.ill = 1'b1;
        return e;
    endfunction

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        cyc++;
        fired_in = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0h expected=none", result);
            end else begin
                e = sb_q.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("ovf", 64'(ovf), 64'(e.ovf));
                chk("illegal", 64'(illegal), 64'(e.ill));
                if (e.chk_lat) chk("latency", 64'(cyc - e.cyc), 64'(LAT));
            end
        end
        if (fired_in) begin
            pend.cyc = cyc;
            sb_q.push_back(pend);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input exp_t e, input bit lat);
        int n = 0;
        in_valid = 1'b1;
        opcode   = op;
        dataa    = a;
        datab    = b;
        pend     = e;
        pend.chk_lat = lat;
        do begin
            cycle();
            n++;
        end while (!fired_in && n < 100);
        if (!fired_in) chk("accept_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (sb_q.size() != 0 && n < 200) begin
            cycle();
            n++;
        end
        chk("drain_left", 64'(sb_q.size()), 64'(0));
        for (int i = 0; i < 6; i++) cycle();
    endtask

    initial begin
        exp_t e;
        int   idx;
        bit   have_held;
        logic [15:0] held;
        logic [15:0] ba [6];

        vecs[0]  = '{4'd0, 16'd3,    16'd4,    16'd7,    1'b0, 1'b0};
        vecs[1]  = '{4'd0, 16'd100,  16'hffff, 16'd99,   1'b0, 1'b0};
        vecs[2]  = '{4'd1, 16'hfffb, 16'd7,    16'hfff4, 1'b0, 1'b0};
        vecs[3]  = '{4'd3, 16'd300,  16'd300,  SAT ? 16'h7fff : 16'h5f90, 1'b1, 1'b0};
        vecs[4]  = '{4'd4, 16'd300,  16'd300,  16'h0001, 1'b0, 1'b0};
        vecs[5]  = '{4'd0, 16'h7fff, 16'h0001, SAT ? 16'h7fff : 16'h8000, 1'b1, 1'b0};
        vecs[6]  = '{4'd1, 16'h8000, 16'h0001, SAT ? 16'h8000 : 16'h7fff, 1'b1, 1'b0};
        vecs[7]  = '{4'd9, 16'd5,    16'd5,    16'h0000, 1'b0, 1'b1};
        vecs[8]  = '{4'd5, 16'hf0f0, 16'h0ff0, 16'h00f0, 1'b0, 1'b0};
        vecs[9]  = '{4'd2, 16'd3,    16'd10,   16'd7,    1'b0, 1'b0};
        vecs[10] = '{4'd2, 16'h0001, 16'h8000, SAT ? 16'h8000 : 16'h7fff, 1'b1, 1'b0};
        vecs[11] = '{4'd3, 16'hfed4, 16'd300,  SAT ? 16'h8000 : 16'ha070, 1'b1, 1'b0};
        vecs[12] = '{4'd4, 16'hfed4, 16'd300,  16'hfffe, 1'b0, 1'b0};
        vecs[13] = '{4'd3, 16'hfffd, 16'd4,    16'hfff4, 1'b0, 1'b0};
        vecs[14] = '{4'd6, 16'h00f0, 16'h0f00, 16'h0ff0, 1'b0, 1'b0};
        vecs[15] = '{4'd15, 16'h1234, 16'h4321, 16'h0000, 1'b0, 1'b1};

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Directed table, back-to-back with sink always ready
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e.res = vecs[i].res; e.ovf = vecs[i].ovf; e.ill = vecs[i].ill;
            e.cyc = 0; e.chk_lat = 1'b0;
            drive(vecs[i].op, vecs[i].a, vecs[i].b, e, 1'b1);
        end
        drain();

        // Backpressure: 6 beats into a stalled sink
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) ba[i] = 16'(i * 1000 + 17);
        idx = 0;
        have_held = 1'b0;
        held = '0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (idx < 6);
            if (idx < 6) begin
                opcode = 4'd0; dataa = ba[idx]; datab = 16'd5;
                pend = model(0, ba[idx], 16'd5);
            end
            cycle();
            if (fired_in) idx++;
            if (out_valid) begin
                if (!have_held) begin
                    held = result;
                    have_held = 1'b1;
                end else chk("held_result", 64'(result), 64'(held));
            end
        end
        chk("held_first_beat", 64'(held), 64'(16'd22));
        chk("stall_accepted", 64'(idx), 64'(LAT));
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            in_valid = 1'b1;
            opcode = 4'd0; dataa = ba[idx]; datab = 16'd5;
            pend = model(0, ba[idx], 16'd5);
            cycle();
            if (fired_in) idx++;
        end
        chk("stall_all_accepted", 64'(idx), 64'(6));
        drain();

        // Async reset with beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive(4'd7, 16'(16'h1111 * (i + 1)), 16'h00ff,
                                          model(7, 16'(16'h1111 * (i + 1)), 16'h00ff), 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        chk("pre_rst_out_valid", 64'(out_valid), 64'(1));
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'(0));
        chk("async_result", 64'(result), 64'(0));
        chk("async_in_ready", 64'(in_ready), 64'(0));
        sb_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(in_ready), 64'(1));
        chk("rel_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        e.res = 16'h00f0; e.ovf = 1'b0; e.ill = 1'b0; e.cyc = 0; e.chk_lat = 1'b0;
        drive(4'd5, 16'hf0f0, 16'h0ff0, e, 1'b1);
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            int op;
            logic [15:0] a, b;
            op = int'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16'h7fff : 16'h8000) : 16'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            opcode = 4'(op);
            dataa  = a;
            datab  = b;
            pend   = model(op, a, b);
            cycle();
        end
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
